// File: rtl/fp32_pkg.sv
// ---------------------------------------------------------------------------
// fp32_pkg
// Shared binary32 types and constants for the MUL functional unit.
//   fp32_t     : packed {sign, exp[7:0], frac[22:0]}
//   fp_flags_t : packed {nv, of, uf, nx} = {invalid, overflow, underflow, inexact}
// ---------------------------------------------------------------------------
package fp32_pkg;

   localparam int          BIAS    = 127;
   localparam int          EXP_MAX = 255;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   typedef struct packed {
      logic nv;
      logic of;
      logic uf;
      logic nx;
   } fp_flags_t;

endpackage

// File: rtl/fp32_multi_if.sv
// ---------------------------------------------------------------------------
// fp32_multi_if
// Operand/result bundle of the binary32 multiplier.
//   a, b     : operands                (master -> slave)
//   op       : combinational product   (slave -> master)
//   op_q     : registered product      (slave -> master)
//   flags_q  : registered {nv,of,uf,nx} (slave -> master)
// ---------------------------------------------------------------------------
interface fp32_multi_if;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] op;
   logic [31:0] op_q;
   logic [3:0]  flags_q;

   modport master (output a, b, input  op, op_q, flags_q);
   modport slave  (input  a, b, output op, op_q, flags_q);
endinterface

// File: rtl/fp32_round_norm.sv
// ---------------------------------------------------------------------------
// fp32_round_norm
// Normalises a 48b significand product, rounds to nearest-even and resolves
// overflow/underflow into a packed binary32 result plus flags.
//   sign_i  : result sign
//   prod_i  : 24b x 24b significand product (nonzero)
//   exp_i   : ea + eb - bias, signed 10b
//   res_o   : rounded result
//   flags_o : {nv(always 0), of, uf, nx}
// FP32_MULTI_SUBNORMAL_EN: when defined, tiny results are denormalised and
// rounded; otherwise they flush to signed zero.
// ---------------------------------------------------------------------------
module fp32_round_norm
   import fp32_pkg::*;
(
   input  logic               sign_i,
   input  logic [47:0]        prod_i,
   input  logic signed [9:0]  exp_i,
   output fp32_t              res_o,
   output fp_flags_t          flags_o
);

   logic [5:0]         lz;
   logic [47:0]        norm;
   logic [47:0]        shifted;
   logic signed [9:0]  exp_n;
   logic signed [9:0]  exp_f;
   logic               tiny;
   logic               sticky_x;
   logic [23:0]        mant;
   logic               guard, rnd, sticky, inexact, inc;
   logic [24:0]        mant_r;
   logic [22:0]        frac_n;
`ifdef FP32_MULTI_SUBNORMAL_EN
   logic signed [9:0]  sh_full;
   logic [5:0]         shamt;
   logic [47:0]        mask;
`endif

   always_comb begin
      lz = '0;
      for (int i = 0; i < 48; i++) begin
         if (prod_i[i]) lz = 6'(47 - i);
      end
      // leading one moved to bit 47; the binary point sits after bit 46,
      // so the exponent gains one and loses the shift distance
      norm     = prod_i << lz;
      exp_n    = exp_i + 10'sd1 - $signed({4'b0, lz});
      tiny     = (exp_n < 10'sd1);
      shifted  = norm;
      sticky_x = 1'b0;
`ifdef FP32_MULTI_SUBNORMAL_EN
      sh_full = 10'sd1 - exp_n;
      shamt   = '0;
      mask    = '0;
      if (tiny) begin
         shamt    = (sh_full > 10'sd48) ? 6'd48 : sh_full[5:0];
         shifted  = norm >> shamt;
         mask     = (48'd1 << shamt) - 48'd1;
         sticky_x = |(norm & mask);
      end
`endif
      mant    = shifted[47:24];
      guard   = shifted[23];
      rnd     = shifted[22];
      sticky  = (|shifted[21:0]) | sticky_x;
      inexact = guard | rnd | sticky;
      inc     = guard & (rnd | sticky | mant[0]);
      mant_r  = {1'b0, mant} + 25'(inc);
      // rounding carry-out: mantissa becomes 1.000.., exponent steps up
      frac_n  = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
      exp_f   = mant_r[24] ? exp_n + 10'sd1 : exp_n;

      res_o      = '0;
      flags_o    = '0;
      res_o.sign = sign_i;
      if (tiny) begin
`ifdef FP32_MULTI_SUBNORMAL_EN
         // a carry into bit 23 lands exactly on the min-normal encoding
         res_o.exp  = {7'b0, mant_r[23]};
         res_o.frac = mant_r[22:0];
         flags_o.uf = inexact;
         flags_o.nx = inexact;
`else
         flags_o.uf = 1'b1;
         flags_o.nx = 1'b1;
`endif
      end else if (exp_f >= 10'(EXP_MAX)) begin
         res_o      = POS_INF | {sign_i, 31'b0};
         flags_o.of = 1'b1;
         flags_o.nx = 1'b1;
      end else begin
         res_o.exp  = exp_f[7:0];
         res_o.frac = frac_n;
         flags_o.nx = inexact;
      end
   end

endmodule

// File: rtl/fp32_multi.sv
// ---------------------------------------------------------------------------
// fp32_multi
// IEEE-754 binary32 multiplier (MUL unit): combinational product plus a
// registered copy with exception flags.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (clears op_q/flags_q only)
//   bus    : fp32_multi_if.slave -- a, b in; op, op_q, flags_q out
// FP32_MULTI_SUBNORMAL_EN: when defined, subnormal operands are honoured
// (hidden bit 0, exponent 1); otherwise they are read as signed zero.
// ---------------------------------------------------------------------------
module fp32_multi
   import fp32_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   fp32_multi_if.slave  bus
);

   fp32_t             a, b;
   logic              sign;
   logic              a_nan, b_nan, a_snan, b_snan;
   logic              a_inf, b_inf, a_zero, b_zero;
   logic [23:0]       ma, mb;
   logic [7:0]        ea, eb;
   logic [47:0]       prod;
   logic signed [9:0] exp_sum;
   fp32_t             rn_res, res;
   fp_flags_t         rn_flags, flg;
   logic [31:0]       op_reg_d, op_reg_q;
   fp_flags_t         flags_reg_d, flags_reg_q;

   assign a = bus.a;
   assign b = bus.b;

   always_comb begin
      sign   = a.sign ^ b.sign;
      a_nan  = (a.exp == 8'hFF) && (a.frac != '0);
      b_nan  = (b.exp == 8'hFF) && (b.frac != '0);
      a_snan = a_nan && !a.frac[22];
      b_snan = b_nan && !b.frac[22];
      a_inf  = (a.exp == 8'hFF) && (a.frac == '0);
      b_inf  = (b.exp == 8'hFF) && (b.frac == '0);
`ifdef FP32_MULTI_SUBNORMAL_EN
      a_zero = (a.exp == '0) && (a.frac == '0);
      b_zero = (b.exp == '0) && (b.frac == '0);
      ma     = {(a.exp != '0), a.frac};
      mb     = {(b.exp != '0), b.frac};
      ea     = (a.exp == '0) ? 8'd1 : a.exp;
      eb     = (b.exp == '0) ? 8'd1 : b.exp;
`else
      a_zero = (a.exp == '0);
      b_zero = (b.exp == '0);
      ma     = {1'b1, a.frac};
      mb     = {1'b1, b.frac};
      ea     = a.exp;
      eb     = b.exp;
`endif
      prod    = {24'b0, ma} * {24'b0, mb};
      exp_sum = $signed({2'b0, ea}) + $signed({2'b0, eb}) - $signed(10'(BIAS));
   end

   fp32_round_norm u_round_norm (
      .sign_i  (sign),
      .prod_i  (prod),
      .exp_i   (exp_sum),
      .res_o   (rn_res),
      .flags_o (rn_flags)
   );

   always_comb begin
      res = rn_res;
      flg = rn_flags;
      if (a_nan || b_nan) begin
         res    = QNAN;
         flg    = '0;
         flg.nv = a_snan | b_snan;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         res    = QNAN;
         flg    = '0;
         flg.nv = 1'b1;
      end else if (a_inf || b_inf) begin
         res = POS_INF | {sign, 31'b0};
         flg = '0;
      end else if (a_zero || b_zero) begin
         res = {sign, 31'b0};
         flg = '0;
      end
      op_reg_d    = res;
      flags_reg_d = flg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg_q    <= '0;
         flags_reg_q <= '0;
      end else begin
         op_reg_q    <= op_reg_d;
         flags_reg_q <= flags_reg_d;
      end
   end

   assign bus.op      = res;
   assign bus.op_q    = op_reg_q;
   assign bus.flags_q = flags_reg_q;

endmodule

// File: tb/tb_fp32_multi.sv
// ---------------------------------------------------------------------------
// tb_fp32_multi
// Directed bench for fp32_multi. Each step drives {a,b} just after posedge,
// checks op at the following negedge and queues the expected registered
// result, which is compared against op_q/flags_q after the next posedge.
// ---------------------------------------------------------------------------
module tb_fp32_multi;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fp32_multi_if bus ();

   fp32_multi u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] op;
      logic [3:0]  fl;
   } vec_t;

   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [3:0] F_NONE = 4'b0000;
   localparam logic [3:0] F_NV   = 4'b1000;
   localparam logic [3:0] F_OFNX = 4'b0101;
   localparam logic [3:0] F_UFNX = 4'b0011;
   localparam logic [3:0] F_NX   = 4'b0001;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic pop_check();
      vec_t v;
      if (sb.size() > 0) begin
         v = sb.pop_front();
         chk($sformatf("op_q %h*%h", v.a, v.b), bus.op_q, v.op);
         chk($sformatf("flags_q %h*%h", v.a, v.b), {28'b0, bus.flags_q}, {28'b0, v.fl});
      end
   endtask

   task automatic apply(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f);
      vec_t v;
      @(posedge clk);
      #1;
      pop_check();
      bus.a = a;
      bus.b = b;
      v.a = a; v.b = b; v.op = r; v.fl = f;
      sb.push_back(v);
      @(negedge clk);
      chk($sformatf("op %h*%h", a, b), bus.op, r);
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
      while (sb.size() > 0) pop_check();
   endtask

   initial begin
      bus.a = 32'h3F80_0000;
      bus.b = 32'h4000_0000;
      #12;
      chk("reset op_q", bus.op_q, 32'h0);
      chk("reset flags_q", {28'b0, bus.flags_q}, 32'h0);
      chk("op during reset", bus.op, 32'h4000_0000);
      @(negedge clk);
      rst_n = 1'b1;

      apply(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, F_NONE);
      apply(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, F_NONE);
      apply(32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, F_NONE);
      apply(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, F_NONE);
      apply(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, F_NONE);
      apply(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, F_NV);
      apply(32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, F_NV);
      apply(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, F_NONE);
      apply(32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, F_NONE);
      apply(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, F_NV);
      apply(32'h7F80_0001, 32'h7F80_0000, 32'h7FC0_0000, F_NV);
      apply(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, F_NONE);
      apply(32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000, F_NONE);
      apply(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, F_OFNX);
      apply(32'hFF00_0000, 32'h4000_0000, 32'hFF80_0000, F_OFNX);
      apply(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, F_NX);
      apply(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, F_NX);   // tie, rounds up to even
      apply(32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, F_NX);   // tie, stays even
      apply(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, F_NONE); // product bit47 set
      apply(32'h3F91_8E00, 32'h3FE1_2000, 32'h4000_0000, F_NX);   // rounding carry-out
      apply(32'h407F_FFFF, 32'h3F80_0000, 32'h407F_FFFF, F_NONE);
      apply(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, F_UFNX);
`ifdef FP32_MULTI_SUBNORMAL_EN
      apply(32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, F_NONE);
      apply(32'h8080_0000, 32'h3F00_0000, 32'h8040_0000, F_NONE);
      apply(32'h0000_0001, 32'h3F80_0000, 32'h0000_0001, F_NONE);
      apply(32'h0000_0003, 32'h3F00_0000, 32'h0000_0002, F_UFNX);
`else
      apply(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, F_UFNX);
      apply(32'h8080_0000, 32'h3F00_0000, 32'h8000_0000, F_UFNX);
      apply(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, F_NONE);
      apply(32'h7F80_0000, 32'h0000_0001, 32'h7FC0_0000, F_NV);
`endif
      apply(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, F_OFNX);
      drain();

      // asynchronous reset in the middle of a cycle
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset op_q", bus.op_q, 32'h0);
      chk("async reset flags_q", {28'b0, bus.flags_q}, 32'h0);
      chk("op unaffected by reset", bus.op, 32'h7F80_0000);
      @(posedge clk);
      #1;
      chk("held reset op_q", bus.op_q, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post reset op_q", bus.op_q, 32'h7F80_0000);
      chk("post reset flags_q", {28'b0, bus.flags_q}, {28'b0, F_OFNX});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
